d_in_debouncer: RTL and testbench

//   Conditions a raw, asynchronous, possibly bouncy level input before it reaches the D flip-flop stage.

---
 rtl/d_ff_pkg.sv | 33 +++
 rtl/d_in_debouncer_sync_chain.sv | 36 +++
 rtl/d_in_debouncer.sv | 177 +++++++++++++++++
 tb/tb_d_in_debouncer.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/d_ff_pkg.sv
// -----------------------------------------------------------------------------
// d_ff_pkg
//   Shared definitions for the D flip-flop input conditioning path.
//   - state_t : debouncer FSM states. The encoding is fixed: bit 1 is the
//               level currently presented on d_clean, and bit 0 marks a
//               pending change that is still being qualified.
//   - DEFAULT_SYNC_STAGES / DEFAULT_DEBOUNCE_CYCLES : default parameter values
//               for d_in_debouncer.
//   - state_level / state_busy : decode helpers for the encoding above.
// -----------------------------------------------------------------------------
package d_ff_pkg;

    typedef enum logic [1:0] {
        IDLE_LO = 2'd0,   // d_clean = 0, input agrees
        WAIT_HI = 2'd1,   // d_clean = 0, qualifying a rise
        IDLE_HI = 2'd2,   // d_clean = 1, input agrees
        WAIT_LO = 2'd3    // d_clean = 1, qualifying a fall
    } state_t;

    localparam int DEFAULT_SYNC_STAGES     = 2;
    localparam int DEFAULT_DEBOUNCE_CYCLES = 4;

    // Level that d_clean carries while the FSM sits in state s.
    function automatic logic state_level(state_t s);
        return s[1];
    endfunction

    // High while a candidate change is being qualified.
    function automatic logic state_busy(state_t s);
        return s[0];
    endfunction

endpackage : d_ff_pkg

// File: rtl/d_in_debouncer_sync_chain.sv
// -----------------------------------------------------------------------------
// sync_chain
//   Multi-flop synchroniser bringing an asynchronous level into clk.
//   Parameters:
//     STAGES   number of flops in the chain (>= 2)
//   Ports:
//     clk      in   clock, rising edge
//     rst      in   synchronous active-high reset, clears the whole chain
//     d_async  in   asynchronous level input
//     d_sync   out  level after STAGES flops; the only copy safe to use
// -----------------------------------------------------------------------------
module sync_chain #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d_async,
    output logic d_sync
);

    logic [STAGES-1:0] chain;

    // NOTE: sequential state is always written with non-blocking assignments,
    // so every flop samples the pre-edge value of its neighbour and the chain
    // shifts by exactly one stage per edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d_async};
        end
    end

    assign d_sync = chain[STAGES-1];

endmodule : sync_chain

// File: rtl/d_in_debouncer.sv
// -----------------------------------------------------------------------------
// d_in_debouncer
//   Conditions a raw, asynchronous, possibly bouncy level input before it
//   reaches the downstream D flip-flop. d_raw is synchronised into clk, then
//   every level change must be seen on DEBOUNCE_CYCLES consecutive enabled
//   samples before it is accepted onto d_clean. Accepted changes produce a
//   one-cycle rise or fall pulse.
//
//   Parameters:
//     SYNC_STAGES      synchroniser depth (>= 2)
//     DEBOUNCE_CYCLES  consecutive differing samples needed to accept (>= 1)
//
//   Ports:
//     clk      in   clock, all state updates on the rising edge
//     rst      in   synchronous active-high reset, overrides everything
//     en       in   filter enable; 0 freezes state, counter and d_clean
//     d_raw    in   raw asynchronous level
//     d_clean  out  debounced level (registered)
//     rise     out  one-cycle pulse when d_clean goes 0->1 (registered)
//     fall     out  one-cycle pulse when d_clean goes 1->0 (registered)
//     busy     out  1 while a candidate change is being qualified (registered)
//
//   Latency: with d_raw stable from sampling edge k, d_clean/rise/fall change
//   at edge k + SYNC_STAGES + DEBOUNCE_CYCLES - 1.
// -----------------------------------------------------------------------------
module d_in_debouncer
    import d_ff_pkg::*;
#(
    parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic d_raw,
    output logic d_clean,
    output logic rise,
    output logic fall,
    output logic busy
);

    // Wide enough to hold DEBOUNCE_CYCLES, although the counter itself never
    // goes past DEBOUNCE_CYCLES-1.
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // With a single-sample filter the first differing sample is accepted
    // immediately and the WAIT_* states are never entered.
    localparam bit SINGLE_SAMPLE = (DEBOUNCE_CYCLES == 1);

    // ------------------------------------------------------------------
    // Elaboration-time parameter checks
    // ------------------------------------------------------------------
    if (SYNC_STAGES < 2) begin : g_bad_sync_stages
        $error("d_in_debouncer: SYNC_STAGES must be >= 2 (got %0d)", SYNC_STAGES);
    end

    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce_cycles
        $error("d_in_debouncer: DEBOUNCE_CYCLES must be >= 1 (got %0d)", DEBOUNCE_CYCLES);
    end

    // ------------------------------------------------------------------
    // Synchroniser: runs every cycle, independent of en
    // ------------------------------------------------------------------
    logic d_sync;

    sync_chain #(
        .STAGES (SYNC_STAGES)
    ) u_sync_chain (
        .clk     (clk),
        .rst     (rst),
        .d_async (d_raw),
        .d_sync  (d_sync)
    );

    // ------------------------------------------------------------------
    // Filter FSM with counter and registered outputs
    // ------------------------------------------------------------------
    state_t          state;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE_LO;
            cnt     <= '0;
            d_clean <= 1'b0;
            rise    <= 1'b0;
            fall    <= 1'b0;
            busy    <= 1'b0;
        end else begin
            // Pulses last exactly one cycle unless re-asserted below.
            rise <= 1'b0;
            fall <= 1'b0;

            // en=0: everything except the pulses simply holds.
            if (en) begin
                unique case (state)
                    IDLE_LO: begin
                        if (d_sync) begin
                            if (SINGLE_SAMPLE) begin
                                state   <= IDLE_HI;
                                d_clean <= 1'b1;
                                rise    <= 1'b1;
                                cnt     <= '0;
                                busy    <= 1'b0;
                            end else begin
                                state <= WAIT_HI;
                                cnt   <= CNT_ONE;
                                busy  <= 1'b1;
                            end
                        end
                    end

                    WAIT_HI: begin
                        if (!d_sync) begin
                            // Bounce: drop the candidate, start over.
                            state <= IDLE_LO;
                            cnt   <= '0;
                            busy  <= 1'b0;
                        end else if (cnt == CNT_LAST) begin
                            state   <= IDLE_HI;
                            d_clean <= 1'b1;
                            rise    <= 1'b1;
                            cnt     <= '0;
                            busy    <= 1'b0;
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end

                    IDLE_HI: begin
                        if (!d_sync) begin
                            if (SINGLE_SAMPLE) begin
                                state   <= IDLE_LO;
                                d_clean <= 1'b0;
                                fall    <= 1'b1;
                                cnt     <= '0;
                                busy    <= 1'b0;
                            end else begin
                                state <= WAIT_LO;
                                cnt   <= CNT_ONE;
                                busy  <= 1'b1;
                            end
                        end
                    end

                    WAIT_LO: begin
                        if (d_sync) begin
                            state <= IDLE_HI;
                            cnt   <= '0;
                            busy  <= 1'b0;
                        end else if (cnt == CNT_LAST) begin
                            state   <= IDLE_LO;
                            d_clean <= 1'b0;
                            fall    <= 1'b1;
                            cnt     <= '0;
                            busy    <= 1'b0;
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end

                    default: begin
                        // Unreachable with a 2-bit enum; recover to a known state.
                        state   <= IDLE_LO;
                        cnt     <= '0;
                        d_clean <= 1'b0;
                        busy    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule : d_in_debouncer

// File: tb/tb_d_in_debouncer.sv
// -----------------------------------------------------------------------------
// tb_d_in_debouncer
//   Self-checking bench for d_in_debouncer at default parameters (S=2, D=4).
//   Directed scenarios check the documented timing; a randomized phase compares
//   the DUT against a run-length model of the filter rules.
// -----------------------------------------------------------------------------
module tb_d_in_debouncer;

    localparam int S = 2;
    localparam int D = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en = 1'b1;
    logic d_raw = 1'b0;
    logic d_clean, rise, fall, busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    d_in_debouncer #(
        .SYNC_STAGES     (S),
        .DEBOUNCE_CYCLES (D)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .d_raw   (d_raw),
        .d_clean (d_clean),
        .rise    (rise),
        .fall    (fall),
        .busy    (busy)
    );

    // ------------------------------------------------------------------
    // Reference model: d_raw delayed by S edges, then a count of how many
    // consecutive enabled samples have disagreed with the accepted level.
    // Reaching D flips the level and emits a pulse.
    // ------------------------------------------------------------------
    logic m_delay[S];
    logic m_clean, m_rise, m_fall, m_busy;
    int   m_run;

    task automatic model_step();
        logic s;
        if (rst) begin
            for (int i = 0; i < S; i++) m_delay[i] = 1'b0;
            m_clean = 1'b0;
            m_run   = 0;
            m_rise  = 1'b0;
            m_fall  = 1'b0;
        end else begin
            s = m_delay[S-1];
            for (int i = S-1; i > 0; i--) m_delay[i] = m_delay[i-1];
            m_delay[0] = d_raw;
            m_rise = 1'b0;
            m_fall = 1'b0;
            if (en) begin
                if (s != m_clean) begin
                    m_run++;
                    if (m_run == D) begin
                        m_clean = s;
                        m_run   = 0;
                        if (s) m_rise = 1'b1;
                        else   m_fall = 1'b1;
                    end
                end else begin
                    m_run = 0;
                end
            end
        end
        m_busy = (m_run != 0);
    endtask

    // One rising edge; model advances with it; returns 1 time unit later.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic settle(input logic level, input int n);
        d_raw = level;
        en    = 1'b1;
        repeat (n) tick();
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        rst   = 1'b1;
        d_raw = 1'b1;
        repeat (2) tick();
        checks++;
        if ({d_clean, rise, fall, busy} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_outputs: got clean/rise/fall/busy=%b required 0000",
                     {d_clean, rise, fall, busy});
        end
        d_raw = 1'b0;
        rst   = 1'b0;
        repeat (3) tick();
        checks++;
        if ({d_clean, rise, fall, busy} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_release_idle_lo: got clean/rise/fall/busy=%b required 0000",
                     {d_clean, rise, fall, busy});
        end
    endtask

    // d_raw rises before edge k; observe after edges k..k+6.
    task automatic test_rise();
        logic [6:0] exp_busy  = 7'b0011100;   // index j = after edge k+j (bit 6 = j=0)
        logic [6:0] exp_clean = 7'b0000011;
        logic [6:0] exp_rise  = 7'b0000010;
        d_raw = 1'b1;
        for (int j = 0; j < 7; j++) begin
            tick();
            checks++;
            if ({busy, d_clean, rise, fall} !==
                {exp_busy[6-j], exp_clean[6-j], exp_rise[6-j], 1'b0}) begin
                errors++;
                $display("FAIL rise_timing k+%0d: got busy/clean/rise/fall=%b required %b",
                         j, {busy, d_clean, rise, fall},
                         {exp_busy[6-j], exp_clean[6-j], exp_rise[6-j], 1'b0});
            end
        end
    endtask

    task automatic test_fall();
        logic [6:0] exp_busy  = 7'b0011100;
        logic [6:0] exp_clean = 7'b1111100;
        logic [6:0] exp_fall  = 7'b0000010;
        d_raw = 1'b0;
        for (int j = 0; j < 7; j++) begin
            tick();
            checks++;
            if ({busy, d_clean, rise, fall} !==
                {exp_busy[6-j], exp_clean[6-j], 1'b0, exp_fall[6-j]}) begin
                errors++;
                $display("FAIL fall_timing k+%0d: got busy/clean/rise/fall=%b required %b",
                         j, {busy, d_clean, rise, fall},
                         {exp_busy[6-j], exp_clean[6-j], 1'b0, exp_fall[6-j]});
            end
        end
    endtask

    // Three-cycle pulse reaches cnt=D-1 then is rejected on the next sample.
    task automatic test_glitch();
        int bad = 0;
        d_raw = 1'b1;
        for (int j = 0; j < 12; j++) begin
            if (j == 3) d_raw = 1'b0;
            tick();
            if (d_clean !== 1'b0 || rise !== 1'b0 || fall !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL glitch_rejected: got %0d cycles with clean/pulse set required 0", bad);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL glitch_busy_clear: got busy=%b required 0", busy);
        end
    endtask

    task automatic test_enable();
        int bad = 0;
        d_raw = 1'b1;
        repeat (4) tick();              // after edge k+3: WAIT_HI, cnt=2
        en = 1'b0;
        repeat (10) begin
            tick();
            if (d_clean !== 1'b0 || rise !== 1'b0 || busy !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL enable_freeze: got %0d bad cycles required 0", bad);
        end
        en = 1'b1;
        tick();
        checks++;
        if ({d_clean, rise} !== 2'b00) begin
            errors++;
            $display("FAIL enable_resume_1: got clean/rise=%b required 00", {d_clean, rise});
        end
        tick();
        checks++;
        if ({d_clean, rise, busy} !== 3'b110) begin
            errors++;
            $display("FAIL enable_resume_2: got clean/rise/busy=%b required 110",
                     {d_clean, rise, busy});
        end
    endtask

    // Enter WAIT_LO from IDLE_HI, then reset.
    task automatic test_reset_mid_wait();
        int bad = 0;
        settle(1'b1, 10);
        d_raw = 1'b0;
        repeat (4) tick();
        checks++;
        if ({d_clean, busy} !== 2'b11) begin
            errors++;
            $display("FAIL wait_lo_entered: got clean/busy=%b required 11", {d_clean, busy});
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({d_clean, busy, fall, rise} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_mid_wait: got clean/busy/fall/rise=%b required 0000",
                     {d_clean, busy, fall, rise});
        end
        repeat (8) begin
            tick();
            if (d_clean !== 1'b0 || fall !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL reset_mid_wait_stays_lo: got %0d bad cycles required 0", bad);
        end
    endtask

    // Bursty random input with occasional disable and rare reset.
    task automatic test_random();
        int hold = 0;
        for (int c = 0; c < 3000; c++) begin
            if (hold == 0) begin
                d_raw = ($urandom_range(0, 1) == 1);
                hold  = $urandom_range(1, 9);
            end
            hold--;
            en  = ($urandom_range(0, 7) != 0);
            rst = ($urandom_range(0, 299) == 0);
            tick();
            checks++;
            if ({d_clean, rise, fall, busy} !== {m_clean, m_rise, m_fall, m_busy}) begin
                errors++;
                $display("FAIL random_cycle %0d: got clean/rise/fall/busy=%b required %b",
                         c, {d_clean, rise, fall, busy}, {m_clean, m_rise, m_fall, m_busy});
            end
            checks++;
            if (rise === 1'b1 && fall === 1'b1) begin
                errors++;
                $display("FAIL random_both_pulses %0d: got rise=1 fall=1 required not both", c);
            end
        end
        rst = 1'b0;
        en  = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < S; i++) m_delay[i] = 1'b0;
        m_clean = 1'b0; m_rise = 1'b0; m_fall = 1'b0; m_busy = 1'b0; m_run = 0;

        test_reset();
        settle(1'b0, 4);
        test_rise();
        settle(1'b1, 4);
        test_fall();
        settle(1'b0, 6);
        test_glitch();
        settle(1'b0, 6);
        test_enable();
        settle(1'b1, 6);
        test_reset_mid_wait();
        test_random();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_d_in_debouncer
